// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg
//   Shared types and helpers for the FIFO write-side arbiter and any later
//   schedulers that use the same round-robin rule.
//   Contents:
//     arb_state_e : arbiter FSM states (IDLE, GRANT)
//     rr_next()   : reference round-robin pick, usable at elaboration time
//                   or from models (the rr_pick module is the hardware version)
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int RR_MAX_N = 32;

  // Returns the first set bit of valid[n-1:0], searching upward from ptr+1
  // and wrapping. With no bit set it returns ptr unchanged.
  function automatic int rr_next(input logic [RR_MAX_N-1:0] valid,
                                 input int ptr,
                                 input int n);
    int idx;
    for (int k = 1; k <= n; k++) begin
      idx = (ptr + k) % n;
      if (valid[idx]) return idx;
    end
    return ptr;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker: rotate the request vector so that
//   position ptr+1 lands at bit 0, priority-encode, then un-rotate the index.
//   Ports:
//     i_valid [N]     request vector
//     i_ptr   [IW]    index of the last winner
//     o_idx   [IW]    winner index (meaningful only when o_any)
//     o_any           at least one request present
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int         w_start;
  int         w_off;
  logic       w_found;
  logic [N-1:0] w_rot;

  always_comb begin
    w_start = (int'(i_ptr) + 1) % N;
    w_rot   = '0;
    for (int i = 0; i < N; i++) begin
      w_rot[i] = i_valid[IW'((w_start + i) % N)];
    end
    w_off   = 0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_rot[i] && !w_found) begin
        w_off   = i;
        w_found = 1'b1;
      end
    end
    o_idx = IW'((w_start + w_off) % N);
    o_any = |i_valid;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Packet-atomic round-robin arbiter sharing one async-FIFO write port among
//   NUM_REQ requesters. Each written word carries the source ID in its top
//   ID_W bits so the read side can demultiplex.
//   Ports:
//     w_clk, w_rst_n        write-domain clock, async active-low reset
//     req_valid/last/data   per-requester packet stream inputs
//     req_ready             per-requester beat accept
//     fifo_w_full           FIFO full flag (registered inside the FIFO)
//     fifo_w_en/w_data      FIFO write strobe and {grant_id, payload}
//     busy, grant_id        grant held / current owner
//     err_overlen           one-cycle pulse after a forced release
//
//   state | meaning
//   ------+-------------------------------------------
//   IDLE  | no grant held; arbitrate among req_valid
//   GRANT | grant_id owns the FIFO port until last beat
import fifo_arb_pkg::*;

module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_PKT    = 64,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          w_clk,
  input  logic                          w_rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_w_full,
  output logic                          fifo_w_en,
  output logic [ID_W+DATA_WIDTH-1:0]    fifo_w_data,
  output logic                          busy,
  output logic [ID_W-1:0]               grant_id,
  output logic                          err_overlen
);

  localparam int CW = $clog2(MAX_PKT + 1);

  arb_state_e            r_state;
  logic [ID_W-1:0]       r_grant_id;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [CW-1:0]         r_beat_cnt;
  logic                  r_err_overlen;

  logic [ID_W-1:0]       w_pick_idx;
  logic                  w_pick_any;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_force;
  logic [DATA_WIDTH-1:0] w_gnt_data;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  // Handshake stays combinational so a granted requester sees ready in the
  // same cycle the FIFO has room; fifo_w_full is a FIFO register, no loop.
  always_comb begin
    req_ready  = '0;
    if (r_state == GRANT) begin
      req_ready[r_grant_id] = !fifo_w_full;
    end
    w_beat      = (r_state == GRANT) && req_valid[r_grant_id] && !fifo_w_full;
    w_last      = req_last[r_grant_id];
    // Forced release on the MAX_PKT-th beat when it is not already the last.
    w_force     = w_beat && !w_last && (r_beat_cnt == CW'(MAX_PKT - 1));
    w_gnt_data  = req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
    fifo_w_en   = w_beat;
    fifo_w_data = {r_grant_id, w_gnt_data};
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state       <= IDLE;
      r_grant_id    <= '0;
      r_rr_ptr      <= ID_W'(NUM_REQ - 1);
      r_beat_cnt    <= '0;
      r_err_overlen <= 1'b0;
    end else begin
      r_err_overlen <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant_id <= w_pick_idx;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (w_beat) begin
            if (w_last || w_force) begin
              r_state       <= IDLE;
              r_rr_ptr      <= r_grant_id;
              r_beat_cnt    <= '0;
              r_err_overlen <= w_force;
            end else if (r_beat_cnt != CW'(MAX_PKT)) begin
              r_beat_cnt <= r_beat_cnt + CW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy        = (r_state == GRANT);
  assign grant_id    = r_grant_id;
  assign err_overlen = r_err_overlen;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Directed bench for fifo_wr_arbiter with MAX_PKT = 4. Requester sources are
//   queues of {last, data} beats; expected FIFO words are pushed in the order
//   the round-robin rule should produce and popped on every fifo_w_en.
module tb_fifo_wr_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MP = 4;
  localparam int IW = 2;

  logic              w_clk   = 1'b0;
  logic              w_rst_n = 1'b1;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_last;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              fifo_w_full;
  logic              fifo_w_en;
  logic [IW+DW-1:0]  fifo_w_data;
  logic              busy;
  logic [IW-1:0]     grant_id;
  logic              err_overlen;

  always #5 w_clk = ~w_clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_PKT(MP)) dut (
    .w_clk       (w_clk),
    .w_rst_n     (w_rst_n),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_w_full (fifo_w_full),
    .fifo_w_en   (fifo_w_en),
    .fifo_w_data (fifo_w_data),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_overlen (err_overlen)
  );

  int               tests = 0;
  int               fails = 0;
  int               cyc   = 0;
  int               wr_cnt = 0;
  int               start;
  int               w0;
  logic [DW:0]      src [N][$];
  logic [IW+DW-1:0] exp_q [$];
  int               wcyc [$];
  int               ecyc [$];
  logic [N-1:0]     stall = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (src[i].size() > 0 && !stall[i]) begin
        req_valid[i]          = 1'b1;
        req_last[i]           = src[i][0][DW];
        req_data[i*DW +: DW]  = src[i][0][DW-1:0];
      end else begin
        req_valid[i]          = 1'b0;
        req_last[i]           = 1'b0;
        req_data[i*DW +: DW]  = '0;
      end
    end
  endtask

  function automatic bit src_empty();
    for (int i = 0; i < N; i++) if (src[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push_src(input int r, input int base, input int len);
    for (int k = 0; k < len; k++) src[r].push_back({(k == len-1), DW'(base + k)});
  endtask

  task automatic push_exp(input int r, input int base, input int len);
    for (int k = 0; k < len; k++) exp_q.push_back({IW'(r), DW'(base + k)});
  endtask

  // One clock: observe at negedge, accept beats at posedge, re-drive at +1.
  task automatic step();
    logic [N-1:0] acc;
    @(negedge w_clk);
    cyc++;
    if (fifo_w_en) begin
      wr_cnt++;
      wcyc.push_back(cyc);
      chk("busy_on_write", busy, 1);
      tests++;
      assert (exp_q.size() > 0) else begin
        fails++;
        $error("FAIL unexpected_write: observed %0h expected no write", fifo_w_data);
      end
      if (exp_q.size() > 0) chk("write_data", fifo_w_data, exp_q.pop_front());
    end
    if (err_overlen) ecyc.push_back(cyc);
    if (fifo_w_full) begin
      chk("full_no_wen", fifo_w_en, 0);
      chk("full_no_ready", req_ready, 0);
    end
    chk("ready_onehot", ($countones(req_ready) <= 1), 1);
    acc = req_valid & req_ready;
    @(posedge w_clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) void'(src[i].pop_front());
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_writes(input int target, input int budget);
    int b = 0;
    while (wr_cnt < target && b < budget) begin step(); b++; end
    chk("wait_writes_timeout", (wr_cnt >= target), 1);
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while ((exp_q.size() > 0 || busy || !src_empty()) && b < budget) begin step(); b++; end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    w_rst_n     = 1'b0;
    fifo_w_full = 1'b0;
    stall       = '0;
    for (int i = 0; i < N; i++) src[i].delete();
    exp_q.delete();
    drive();
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_fifo_w_en", fifo_w_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_overlen", err_overlen, 0);
    chk("rst_grant_id", grant_id, 0);
    @(posedge w_clk);
    #1;
    w_rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    fifo_w_full = 1'b0;
    drive();
    #2;
    do_reset();

    // Single requester, 3-beat packet: writes 2, 3, 4 cycles after request.
    push_src(2, 'hA0, 3);
    push_exp(2, 'hA0, 3);
    wcyc.delete();
    start = cyc;
    drive();
    drain(40);
    chk("t1_nwrites", wcyc.size(), 3);
    if (wcyc.size() == 3) begin
      chk("t1_beat0_cyc", wcyc[0], start + 2);
      chk("t1_beat1_cyc", wcyc[1], start + 3);
      chk("t1_beat2_cyc", wcyc[2], start + 4);
    end
    chk("t1_busy_drop_cyc", cyc, start + 4);
    chk("t1_busy_low", busy, 0);

    // All four requesters, 1-beat packets, from reset: order 0,1,2,3,0,1,2,3.
    do_reset();
    for (int i = 0; i < N; i++) begin
      push_src(i, 'h40 + i*16, 1);
      push_src(i, 'h41 + i*16, 1);
    end
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) push_exp(i, 'h40 + i*16 + k, 1);
    wcyc.delete();
    start = cyc;
    drive();
    drain(60);
    chk("t2_nwrites", wcyc.size(), 8);
    if (wcyc.size() == 8) begin
      chk("t2_first_cyc", wcyc[0], start + 2);
      for (int k = 1; k < 8; k++) chk("t2_gap", wcyc[k] - wcyc[k-1], 2);
    end

    // Backpressure mid-packet; last beat lands exactly on MAX_PKT.
    ecyc.delete();
    wcyc.delete();
    push_src(3, 'hC0, 4);
    push_exp(3, 'hC0, 4);
    drive();
    wait_writes(wr_cnt + 2, 20);
    fifo_w_full = 1'b1;
    w0 = wr_cnt;
    run(5);
    chk("t3_no_write_full", wr_cnt, w0);
    chk("t3_grant_held", busy, 1);
    fifo_w_full = 1'b0;
    drain(30);
    chk("t3_nwrites", wcyc.size(), 4);
    chk("t3_no_err", ecyc.size(), 0);

    // Overlength, requester 1 alone: forced release after beat 4.
    ecyc.delete();
    wcyc.delete();
    push_src(1, 'h50, 6);
    push_exp(1, 'h50, 6);
    drive();
    drain(40);
    chk("t4a_nwrites", wcyc.size(), 6);
    chk("t4a_err_count", ecyc.size(), 1);
    if (wcyc.size() == 6 && ecyc.size() == 1) begin
      chk("t4a_err_cyc", ecyc[0], wcyc[3] + 1);
      chk("t4a_rearb_gap", wcyc[4] - wcyc[3], 2);
    end

    // Overlength with requester 2 pending: it wins before the remaining beats.
    ecyc.delete();
    push_src(1, 'h60, 6);
    push_exp(1, 'h60, 4);
    push_exp(2, 'h70, 1);
    push_exp(1, 'h64, 2);
    drive();
    wait_writes(wr_cnt + 2, 20);
    push_src(2, 'h70, 1);
    drive();
    drain(40);
    chk("t4b_err_count", ecyc.size(), 1);

    // Reset after beat 2 of 5, then requester 0 must win over requester 2.
    push_src(3, 'h80, 5);
    push_exp(3, 'h80, 2);
    drive();
    wait_writes(wr_cnt + 2, 20);
    chk("t5_busy_before_rst", busy, 1);
    chk("t5_exp_consumed", exp_q.size(), 0);
    w0 = wr_cnt;
    do_reset();
    chk("t5_no_write_in_rst", wr_cnt, w0);
    push_src(2, 'h90, 1);
    push_src(0, 'h91, 1);
    push_exp(0, 'h91, 1);
    push_exp(2, 'h90, 1);
    drive();
    drain(30);

    // Stalled granted requester keeps the grant; requester 1 waits.
    push_src(0, 'hB0, 4);
    push_src(1, 'hB8, 1);
    push_exp(0, 'hB0, 4);
    push_exp(1, 'hB8, 1);
    drive();
    wait_writes(wr_cnt + 1, 20);
    stall[0] = 1'b1;
    drive();
    w0 = wr_cnt;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t6_busy_held", busy, 1);
      chk("t6_grant_held", grant_id, 0);
      chk("t6_other_ready", req_ready[1], 0);
    end
    chk("t6_no_write_stall", wr_cnt, w0);
    stall[0] = 1'b0;
    drive();
    drain(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
